// File: rtl/spi_ram_sp_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_ram_sp_if
//  Description : Command/response bundle between the SPI slave and spi_ram_sp.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_ram_sp_if;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;

    modport master (
        output din,
        output rx_valid,
        input  dout,
        input  tx_valid
    );

    modport slave (
        input  din,
        input  rx_valid,
        output dout,
        output tx_valid
    );
endinterface
`default_nettype wire

// File: rtl/spi_ram_sp.sv
`default_nettype none
// ============================================================================
//  Module      : spi_ram_sp
//  Description : Single-port RAM behind the SPI slave. Decodes 10-bit command
//                words (opcode + payload) into address loads, writes and reads.
//                Optional macro ADDR_AUTOINC_EN: post-increment wr/rd addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_sp #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    spi_ram_sp_if.slave     bus
);

    localparam int          c_IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0] c_DEPTH   = 32'(MEM_DEPTH);
    localparam logic [1:0]  c_OP_WADDR = 2'b00;
    localparam logic [1:0]  c_OP_WRITE = 2'b01;
    localparam logic [1:0]  c_OP_RADDR = 2'b10;
    localparam logic [1:0]  c_OP_READ  = 2'b11;

    logic [7:0]           r_mem [MEM_DEPTH];
    logic                 r_rx_valid_d;
    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [ADDR_SIZE-1:0] r_rd_addr;
    logic [7:0]           r_dout;
    logic                 r_tx_valid;

    logic                 w_accept;
    logic [1:0]           w_op;
    logic [ADDR_SIZE-1:0] w_addr;
    logic                 w_wr_in_range;
    logic                 w_rd_in_range;
    logic [c_IDX_W-1:0]   w_wr_idx;
    logic [c_IDX_W-1:0]   w_rd_idx;

    // A command is taken only on the first cycle of an rx_valid level.
    assign w_accept      = bus.rx_valid & ~r_rx_valid_d;
    assign w_op          = bus.din[9:8];
    assign w_addr        = bus.din[ADDR_SIZE-1:0];
    assign w_wr_in_range = (32'(r_wr_addr) < c_DEPTH);
    assign w_rd_in_range = (32'(r_rd_addr) < c_DEPTH);
    assign w_wr_idx      = c_IDX_W'(r_wr_addr);
    assign w_rd_idx      = c_IDX_W'(r_rd_addr);

`ifdef ADDR_AUTOINC_EN
    // Wraps at the last valid word; out-of-range addresses roll over naturally.
    function automatic logic [ADDR_SIZE-1:0] f_inc(input logic [ADDR_SIZE-1:0] a);
        if (32'(a) == c_DEPTH - 32'd1) begin
            return '0;
        end
        return a + 1'b1;
    endfunction
`endif

    // Storage has no reset so it maps onto a RAM macro.
    always_ff @(posedge clk) begin
        if (w_accept && (w_op == c_OP_WRITE) && w_wr_in_range) begin
            r_mem[w_wr_idx] <= bus.din[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_valid_d <= 1'b0;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_dout       <= 8'h00;
            r_tx_valid   <= 1'b0;
        end else begin
            r_rx_valid_d <= bus.rx_valid;
            r_tx_valid   <= 1'b0;
            if (w_accept) begin
                case (w_op)
                    c_OP_WADDR: r_wr_addr <= w_addr;
                    c_OP_WRITE: begin
`ifdef ADDR_AUTOINC_EN
                        r_wr_addr <= f_inc(r_wr_addr);
`endif
                    end
                    c_OP_RADDR: r_rd_addr <= w_addr;
                    c_OP_READ: begin
                        r_dout     <= w_rd_in_range ? r_mem[w_rd_idx] : 8'h00;
                        r_tx_valid <= 1'b1;
`ifdef ADDR_AUTOINC_EN
                        r_rd_addr  <= f_inc(r_rd_addr);
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.dout     = r_dout;
    assign bus.tx_valid = r_tx_valid;

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_sp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_ram_sp
//  Description : Directed bench for spi_ram_sp; drives a 256-deep and a
//                128-deep instance in lockstep against an array-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_ram_sp;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_ram_sp_if bus0 ();
    spi_ram_sp_if bus1 ();

    spi_ram_sp #(.MEM_DEPTH(256), .ADDR_SIZE(8)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    spi_ram_sp #(.MEM_DEPTH(128), .ADDR_SIZE(8)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int vectors     = 0;
    int miscompares = 0;

    // Model state, one slot per instance.
    int         depth   [2];
    logic [7:0] m_mem   [2][256];
    bit         m_known [2][256];
    int         m_wr    [2];
    int         m_rd    [2];
    logic [7:0] e_dout  [2];
    bit         e_known [2];
    bit         e_tx    [2];
    bit         chk_en  = 1'b0;
    int         pulses0 = 0;
    int         pulses1 = 0;

    function automatic int nxt(input int k, input int a);
        if (a == depth[k] - 1) return 0;
        return (a + 1) % 256;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_wr[k] = 0; m_rd[k] = 0;
            e_dout[k] = 8'h00; e_known[k] = 1'b1; e_tx[k] = 1'b0;
        end
    endtask

    task automatic model_apply(input logic [1:0] op, input logic [7:0] d);
        for (int k = 0; k < 2; k++) begin
            case (op)
                2'b00: m_wr[k] = int'(d);
                2'b01: begin
                    if (m_wr[k] < depth[k]) begin
                        m_mem[k][m_wr[k]]   = d;
                        m_known[k][m_wr[k]] = 1'b1;
                    end
`ifdef ADDR_AUTOINC_EN
                    m_wr[k] = nxt(k, m_wr[k]);
`endif
                end
                2'b10: m_rd[k] = int'(d);
                default: begin
                    e_tx[k] = 1'b1;
                    if (m_rd[k] < depth[k]) begin
                        e_dout[k]  = m_mem[k][m_rd[k]];
                        e_known[k] = m_known[k][m_rd[k]];
                    end else begin
                        e_dout[k]  = 8'h00;
                        e_known[k] = 1'b1;
                    end
`ifdef ADDR_AUTOINC_EN
                    m_rd[k] = nxt(k, m_rd[k]);
`endif
                end
            endcase
        end
    endtask

    task automatic drive(input logic [9:0] w, input logic v);
        bus0.din = w; bus1.din = w;
        bus0.rx_valid = v; bus1.rx_valid = v;
    endtask

    task automatic clear_tx();
        e_tx[0] = 1'b0; e_tx[1] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); clear_tx(); #1;
        end
    endtask

    task automatic cmd(input logic [1:0] op, input logic [7:0] d, input int hold = 1);
        drive({op, d}, 1'b1);
        @(posedge clk); clear_tx(); model_apply(op, d); #1;
        for (int i = 1; i < hold; i++) begin
            @(posedge clk); clear_tx(); #1;
        end
        drive({op, d}, 1'b0);
        idle(1);
    endtask

    task automatic check_lit(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus0.tx_valid === 1'b1) pulses0++;
        if (bus1.tx_valid === 1'b1) pulses1++;
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (((k == 0 ? bus0.tx_valid : bus1.tx_valid) !== e_tx[k]) ||
                    (e_known[k] && ((k == 0 ? bus0.dout : bus1.dout) !== e_dout[k]))) begin
                    miscompares++;
                    $display("FAIL cycle_dut%0d @%0t: dout=%h tx_valid=%b expected dout=%h tx_valid=%b",
                             k, $time, (k == 0 ? bus0.dout : bus1.dout),
                             (k == 0 ? bus0.tx_valid : bus1.tx_valid), e_dout[k], e_tx[k]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        int p0;
        int p1;
        depth[0] = 256; depth[1] = 128;
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 256; a++) m_known[k][a] = 1'b0;
        model_reset();
        drive(10'h000, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_lit("reset_dout", bus0.dout, 8'h00);
        check_lit("reset_tx", {7'b0, bus0.tx_valid}, 8'h00);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        idle(2);

        // Basic address/write/address/read sequence
        cmd(2'b00, 8'h3C);
        cmd(2'b01, 8'hA5);
        cmd(2'b10, 8'h3C);
        p0 = pulses0;
        cmd(2'b11, 8'h00);
        check_lit("basic_dout0", bus0.dout, 8'hA5);
        check_lit("basic_dout1", bus1.dout, 8'hA5);
        check_lit("basic_pulse", 8'(pulses0 - p0), 8'h01);

        // Reset while a read response is pending
        cmd(2'b10, 8'h3C);
        drive({2'b11, 8'h00}, 1'b1);
        @(posedge clk); clear_tx(); model_apply(2'b11, 8'h00); #1;
        check_lit("pending_tx", {7'b0, bus0.tx_valid}, 8'h01);
        #2;
        rst_n = 1'b0;
        model_reset();
        drive(10'h000, 1'b0);
        #1;
        check_lit("midrst_dout", bus0.dout, 8'h00);
        check_lit("midrst_tx", {7'b0, bus0.tx_valid}, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        // Addresses cleared: write then read with no address commands hits word 0
        cmd(2'b01, 8'h5A);
        cmd(2'b11, 8'h00);
        check_lit("addr0_dout0", bus0.dout, 8'h5A);
        check_lit("addr0_dout1", bus1.dout, 8'h5A);

        // Long rx_valid level is one command
        cmd(2'b10, 8'h3C);
        p0 = pulses0;
        cmd(2'b11, 8'h00, 5);
        check_lit("hold_pulse", 8'(pulses0 - p0), 8'h01);
        check_lit("hold_dout", bus0.dout, 8'hA5);

        // Two locations, independent address registers
        cmd(2'b00, 8'h05); cmd(2'b01, 8'h11);
        cmd(2'b00, 8'h06); cmd(2'b01, 8'h22);
        cmd(2'b10, 8'h05); cmd(2'b11, 8'h00);
        check_lit("rd05", bus0.dout, 8'h11);
        cmd(2'b10, 8'h06); cmd(2'b11, 8'h00);
        check_lit("rd06", bus0.dout, 8'h22);
        cmd(2'b10, 8'h05); cmd(2'b00, 8'h40); cmd(2'b11, 8'h00);
        check_lit("rd_indep", bus0.dout, 8'h11);
        cmd(2'b00, 8'h07); cmd(2'b10, 8'h05); cmd(2'b01, 8'h44);
        cmd(2'b10, 8'h07); cmd(2'b11, 8'h00);
        check_lit("wr_indep", bus0.dout, 8'h44);

        // Out of range on the 128-deep instance
        cmd(2'b00, 8'h80); cmd(2'b01, 8'h77); cmd(2'b10, 8'h80);
        p1 = pulses1;
        cmd(2'b11, 8'h00);
        check_lit("oor_dout1", bus1.dout, 8'h00);
        check_lit("oor_pulse1", 8'(pulses1 - p1), 8'h01);
        check_lit("inrange_dout0", bus0.dout, 8'h77);
        cmd(2'b10, 8'h00); cmd(2'b11, 8'h00);
        check_lit("mem0_kept1", bus1.dout, 8'h5A);

`ifdef ADDR_AUTOINC_EN
        cmd(2'b00, 8'hFF); cmd(2'b01, 8'hAA); cmd(2'b01, 8'hBB);
        cmd(2'b10, 8'hFF);
        cmd(2'b11, 8'h00);
        check_lit("inc_rdFF", bus0.dout, 8'hAA);
        cmd(2'b11, 8'h00);
        check_lit("inc_rd00", bus0.dout, 8'hBB);
        check_lit("inc_rd00_d1", bus1.dout, 8'hBB);
`else
        cmd(2'b10, 8'h05);
        cmd(2'b11, 8'h00);
        cmd(2'b11, 8'h00);
        check_lit("noinc_reread", bus0.dout, 8'h11);
`endif

        idle(2);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
